// File: rtl/vm_event_timer.sv
// Line-clock event generator with debounced enable toggle, pulse/level event
// delivery with overrun detection, and a 1-in-N CPU clock-enable strobe.
module vm_event_timer #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned EVT_HZ0    = 50,
  parameter int unsigned EVT_HZ1    = 60,
  parameter int unsigned DEB_DEPTH  = 2,
  parameter int unsigned LEVEL_MODE = 0,
  parameter int unsigned SLOW_DIV   = 22,
  parameter int unsigned ENA_INIT   = 0
) (
  input  logic clk_p,
  input  logic dclo,
  input  logic timer_button,
  input  logic rate_sel,
  input  logic cpuslow,
  input  logic evt_ack,
  output logic cpu_clk_enable,
  output logic vm_evnt,
  output logic timer_status,
  output logic evt_overrun,
  output logic tick
);

  localparam int unsigned DIV0 = CLK_HZ / EVT_HZ0;
  localparam int unsigned DIV1 = CLK_HZ / EVT_HZ1;
  localparam int unsigned DIVM = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned CW   = (DIVM > 2) ? $clog2(DIVM) : 1;
  localparam int unsigned SW   = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;

  localparam logic [CW-1:0] LAST0 = CW'(DIV0 - 1);
  localparam logic [CW-1:0] LAST1 = CW'(DIV1 - 1);
  localparam logic [SW-1:0] SLAST = SW'(SLOW_DIV - 1);

  logic                 btn_m, btn_s;
  logic                 slow_m, slow_s;
  logic [CW-1:0]        cnt;
  logic                 sel_q;
  logic                 period_end;
  logic [DEB_DEPTH-1:0] sh;
  logic [DEB_DEPTH-1:0] sh_nxt;
  logic                 armed;
  logic                 fire;
  logic [SW-1:0]        scnt;

  // Two-flop synchronisers for the asynchronous button and slow switch
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
      slow_m <= 1'b0;
      slow_s <= 1'b0;
    end else begin
      btn_m  <= timer_button;
      btn_s  <= btn_m;
      slow_m <= cpuslow;
      slow_s <= slow_m;
    end
  end

  // Rate is latched only at period end so a period is never truncated
  assign period_end = (cnt == (sel_q ? LAST1 : LAST0));

  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      cnt   <= '0;
      tick  <= 1'b0;
      sel_q <= 1'b0;
    end else if (period_end) begin
      cnt   <= '0;
      tick  <= 1'b1;
      sel_q <= rate_sel;
    end else begin
      cnt   <= cnt + CW'(1);
      tick  <= 1'b0;
    end
  end

  assign sh_nxt = {sh[DEB_DEPTH-2:0], btn_s};

  // Toggle once per stable press; re-arm only after a stable release
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      sh           <= '0;
      armed        <= 1'b1;
      timer_status <= (ENA_INIT != 0);
    end else if (tick) begin
      sh <= sh_nxt;
      if ((&sh_nxt) && armed) begin
        timer_status <= ~timer_status;
        armed        <= 1'b0;
      end else if (~|sh_nxt) begin
        armed <= 1'b1;
      end
    end
  end

  assign fire = tick & timer_status;

  generate
    if (LEVEL_MODE != 0) begin : g_level
      // vm_evnt doubles as the pending flag; a same-edge fire beats the ack
      always_ff @(posedge clk_p or posedge dclo) begin
        if (dclo) begin
          vm_evnt     <= 1'b0;
          evt_overrun <= 1'b0;
        end else begin
          vm_evnt     <= fire | (vm_evnt & ~evt_ack);
          evt_overrun <= (fire & vm_evnt & ~evt_ack) | (evt_overrun & ~evt_ack);
        end
      end
    end else begin : g_pulse
      logic unused_ack;
      assign unused_ack  = evt_ack;
      assign evt_overrun = 1'b0;

      always_ff @(posedge clk_p or posedge dclo) begin
        if (dclo) begin
          vm_evnt <= 1'b0;
        end else begin
          vm_evnt <= fire;
        end
      end
    end
  endgenerate

  // Free-running slow-mode divider
  always_ff @(posedge clk_p or posedge dclo) begin
    if (dclo) begin
      scnt <= '0;
    end else if (scnt == SLAST) begin
      scnt <= '0;
    end else begin
      scnt <= scnt + SW'(1);
    end
  end

  assign cpu_clk_enable = ~slow_s | (scnt == '0);

endmodule

// File: tb/tb_vm_event_timer.sv
// Directed bench for vm_event_timer: pulse instance (enabled), level instance
// (enabled) and a pulse instance starting disabled for the button toggle.
module tb_vm_event_timer;

  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned EVT_HZ0  = 50;
  localparam int unsigned EVT_HZ1  = 100;
  localparam int unsigned DEB      = 2;
  localparam int unsigned SLOW_DIV = 22;

  logic clk_p, dclo, rate_sel, cpuslow, ack, btn_ab, btn_c;
  logic a_ena, a_evnt, a_status, a_ovr, a_tick;
  logic b_ena, b_evnt, b_status, b_ovr, b_tick;
  logic c_ena, c_evnt, c_status, c_ovr, c_tick;

  int n_chk;
  int n_fail;
  int cyc;

  vm_event_timer #(.CLK_HZ(CLK_HZ), .EVT_HZ0(EVT_HZ0), .EVT_HZ1(EVT_HZ1), .DEB_DEPTH(DEB),
                   .LEVEL_MODE(0), .SLOW_DIV(SLOW_DIV), .ENA_INIT(1)) u_a (
    .clk_p(clk_p), .dclo(dclo), .timer_button(btn_ab), .rate_sel(rate_sel),
    .cpuslow(cpuslow), .evt_ack(ack), .cpu_clk_enable(a_ena), .vm_evnt(a_evnt),
    .timer_status(a_status), .evt_overrun(a_ovr), .tick(a_tick));

  vm_event_timer #(.CLK_HZ(CLK_HZ), .EVT_HZ0(EVT_HZ0), .EVT_HZ1(EVT_HZ1), .DEB_DEPTH(DEB),
                   .LEVEL_MODE(1), .SLOW_DIV(SLOW_DIV), .ENA_INIT(1)) u_b (
    .clk_p(clk_p), .dclo(dclo), .timer_button(btn_ab), .rate_sel(rate_sel),
    .cpuslow(cpuslow), .evt_ack(ack), .cpu_clk_enable(b_ena), .vm_evnt(b_evnt),
    .timer_status(b_status), .evt_overrun(b_ovr), .tick(b_tick));

  vm_event_timer #(.CLK_HZ(CLK_HZ), .EVT_HZ0(EVT_HZ0), .EVT_HZ1(EVT_HZ1), .DEB_DEPTH(DEB),
                   .LEVEL_MODE(0), .SLOW_DIV(SLOW_DIV), .ENA_INIT(0)) u_c (
    .clk_p(clk_p), .dclo(dclo), .timer_button(btn_c), .rate_sel(rate_sel),
    .cpuslow(cpuslow), .evt_ack(ack), .cpu_clk_enable(c_ena), .vm_evnt(c_evnt),
    .timer_status(c_status), .evt_overrun(c_ovr), .tick(c_tick));

  initial begin
    clk_p = 1'b0;
    forever #5 clk_p = ~clk_p;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int   cyc;
    logic rs;
    logic ack;
    logic tk;
    logic a_ev;
    logic b_ev;
    logic b_ov;
  } vec_t;

  vec_t tbl[15];

  task automatic step();
    @(posedge clk_p);
    @(negedge clk_p);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_dut();
    dclo = 1'b1;
    step();
    step();
    dclo = 1'b0;
    cyc  = 0;
  endtask

  task automatic wait_b_tick();
    int n = 0;
    while (b_tick !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("b_tick_arrives", b_tick, 1'b1);
  endtask

  // Advance through the next C tick and its sampling edge
  task automatic sample_c();
    int n = 0;
    while (c_tick !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("c_tick_arrives", c_tick, 1'b1);
    step();
  endtask

  initial begin
    int hi;
    int n;
    n_chk = 0; n_fail = 0; cyc = 0;
    dclo = 1'b1; rate_sel = 1'b0; cpuslow = 1'b0; ack = 1'b0;
    btn_ab = 1'b0; btn_c = 1'b0;

    //          cyc  rs    ack   tick  a_ev  b_ev  b_ov
    tbl[0]  = '{19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{41, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{49, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{51, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{60, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{70, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{71, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{72, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values
    step();
    chk("rst_tick", a_tick, 1'b0);
    chk("rst_a_evnt", a_evnt, 1'b0);
    chk("rst_b_evnt", b_evnt, 1'b0);
    chk("rst_b_ovr", b_ovr, 1'b0);
    chk("rst_a_status", a_status, 1'b1);
    chk("rst_c_status", c_status, 1'b0);
    chk("rst_ena", a_ena, 1'b1);
    dclo = 1'b0;
    cyc  = 0;

    // First ticks, rate switch, pulse events, level pend/overrun, one ack
    for (int k = 0; k < 15; k++) begin
      rate_sel = tbl[k].rs;
      ack      = tbl[k].ack;
      while (cyc < tbl[k].cyc) step();
      chk("vec_tick", a_tick, tbl[k].tk);
      chk("vec_a_evnt", a_evnt, tbl[k].a_ev);
      chk("vec_a_ovr", a_ovr, 1'b0);
      chk("vec_b_evnt", b_evnt, tbl[k].b_ev);
      chk("vec_b_ovr", b_ovr, tbl[k].b_ov);
    end
    ack = 1'b0;
    rate_sel = 1'b0;

    // Debounce / toggle on instance C
    reset_dut();
    sample_c();
    btn_c = 1'b1;
    sample_c(); chk("deb_press_s1", c_status, 1'b0);
    sample_c(); chk("deb_press_s2", c_status, 1'b1);
    chk("deb_evnt_same_edge", c_evnt, 1'b0);
    sample_c(); chk("deb_press_s3", c_status, 1'b1);
    chk("deb_evnt_next_tick", c_evnt, 1'b1);
    sample_c(); sample_c(); chk("deb_held", c_status, 1'b1);
    btn_c = 1'b0;
    sample_c(); sample_c(); chk("deb_release", c_status, 1'b1);
    btn_c = 1'b1;
    sample_c(); chk("deb_glitch_s1", c_status, 1'b1);
    btn_c = 1'b0;
    sample_c(); sample_c(); chk("deb_glitch_after", c_status, 1'b1);
    btn_c = 1'b1;
    sample_c(); chk("deb_press2_s1", c_status, 1'b1);
    sample_c(); chk("deb_press2_s2", c_status, 1'b0);
    sample_c(); chk("deb_press2_s3", c_status, 1'b0);
    btn_c = 1'b0;

    // Level mode acknowledge handling on instance B
    reset_dut();
    n = 0;
    while (b_evnt !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk_int("lvl_rise_cycle", cyc, 21);
    repeat (4) step();
    chk("lvl_held", b_evnt, 1'b1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("lvl_ack_clears", b_evnt, 1'b0);
    chk("lvl_ack_ovr", b_ovr, 1'b0);
    wait_b_tick();
    ack = 1'b1; step(); ack = 1'b0;
    chk("lvl_ack_fire_evnt", b_evnt, 1'b1);
    chk("lvl_ack_fire_ovr", b_ovr, 1'b0);
    chk("pulse_ignores_ack", a_evnt, 1'b1);
    wait_b_tick();
    ack = 1'b1; step(); ack = 1'b0;
    chk("lvl_pend_ack_fire_evnt", b_evnt, 1'b1);
    chk("lvl_pend_ack_fire_ovr", b_ovr, 1'b0);
    step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("lvl_final_ack", b_evnt, 1'b0);

    // Slow CPU enable, then reset mid-period with an event pending
    cpuslow = 1'b1;
    dclo = 1'b1;
    step();
    chk("slow_rst_ena", a_ena, 1'b1);
    dclo = 1'b0;
    cyc  = 0;
    hi   = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (cyc >= 3 && a_ena === 1'b1) hi++;
      if (cyc == 21) chk("slow_ena_21", a_ena, 1'b0);
      if (cyc == 22) chk("slow_ena_22", a_ena, 1'b1);
    end
    chk_int("slow_hi_count", hi, 1);
    chk("pend_before_rst", b_evnt, 1'b1);
    dclo = 1'b1;
    #1;
    chk("midrst_ena", a_ena, 1'b1);
    chk("midrst_a_evnt", a_evnt, 1'b0);
    chk("midrst_b_evnt", b_evnt, 1'b0);
    chk("midrst_tick", a_tick, 1'b0);
    step();
    dclo = 1'b0;
    cyc  = 0;
    step();
    chk("postrst_ena", a_ena, 1'b1);
    chk("postrst_b_evnt", b_evnt, 1'b0);
    while (cyc < 19) step();
    chk("postrst_tick19", a_tick, 1'b0);
    step();
    chk("postrst_tick20", a_tick, 1'b1);
    cpuslow = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
